lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 Parameter EXCL_BORDER, default 1: when 1, samples whose lbp_addr lies on the 128x128 image border are not counted.
REQ-002 Parameter CNT_W, default 15: histogram bin count width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 lbp_valid  input  1  LBP sample strobe from the upstream LBP stage.
REQ-006 lbp_addr  input  14  pixel address of the sample: row in [13:7], column in [6:0].
REQ-007 lbp_data  input  8  LBP code; selects the bin.
REQ-008 finish  input  1  upstream frame-complete pulse.
REQ-009 acc_ready  output  1  high only in ACCUM; samples are accepted only then.
REQ-010 hist_valid  output  1  readout beat valid.
REQ-011 hist_ready  input  1  downstream accepts a beat when high together with hist_valid.
REQ-012 hist_bin  output  8  bin index of the current beat.
REQ-013 hist_count  output  CNT_W  count of the current beat.
REQ-014 hist_done  output  1  one-cycle pulse after bin 255 is accepted.
REQ-015 drop_err  output  1  sticky flag: lbp_valid seen while acc_ready is low.

Function
REQ-016 FSM states: CLEAR, ACCUM, DRAIN, READOUT, DONE.
REQ-017 CLEAR writes zero to bins 0..255, one bin per cycle (256 cycles), then enters ACCUM.
REQ-018 ACCUM: each accepted sample increments bin[lbp_data] by 1 through a 2-stage read-modify-write pipeline (read, then write).
REQ-019 Bin memory has 1-cycle synchronous read latency.
REQ-020 Samples may arrive every cycle; equal codes on consecutive or alternate cycles are forwarded from the write stage, so no increment is lost.
REQ-021 Border rule, EXCL_BORDER=1: a sample is ignored when row==0, row==127, col==0 or col==127.
REQ-022 An increment saturates at 2^CNT_W-1.
REQ-023 A finish pulse in ACCUM moves to DRAIN; a sample on the same cycle as finish is still counted.
REQ-024 DRAIN lasts exactly 2 cycles so the pipeline empties, then moves to READOUT.
REQ-025 READOUT presents bins in order 0..255.
REQ-026 hist_valid first rises 2 cycles after READOUT entry.
REQ-027 While hist_valid=1 and hist_ready=0, hist_bin and hist_count are held stable.
REQ-028 Each accepted beat writes zero back to its bin, so no CLEAR is needed between frames.
REQ-029 After bin 255 is accepted: DONE for one cycle with hist_done=1, then ACCUM.
REQ-030 lbp_valid while acc_ready=0 sets drop_err; only reset clears it.
REQ-031 finish outside ACCUM is ignored.

Reset
REQ-032 On reset assertion, all outputs go low asynchronously: hist_bin=0, hist_count=0, drop_err=0, acc_ready=0.
REQ-033 On reset release the FSM enters CLEAR.
REQ-034 Reset mid-operation (any state) discards partial counts; operation restarts with a full CLEAR.
REQ-035 Bin memory contents are not reset; CLEAR establishes them.

Structure
REQ-036 A shared package holds the state encoding, IMG_DIM=128, NUM_BINS=256 and the border-test constants.
REQ-037 The bin storage is one sub-module, lbp_hist_ram: 256 x CNT_W, one synchronous read port and one write port.
REQ-038 Forwarding and saturation logic live in lbp_hist, not in lbp_hist_ram.

Verification
REQ-039 Reset, wait for acc_ready.
- Stream 16384 raster samples, all lbp_data=0x00, EXCL_BORDER=1, then finish.
- Readout: bin0=15876, all other bins 0, hist_done once.
REQ-040 Back-to-back interior samples, codes 5,5,5,7,5 on consecutive cycles, then finish.
- Readout: bin5=4, bin7=1.
REQ-041 Readout with hist_ready toggled 1-0-0-1: hist_bin and hist_count stay stable during stalls; 256 beats delivered, bins in order.
REQ-042 Second frame immediately after hist_done: 10 interior samples of code 0xFF.
- Readout: bin255=10, every other bin 0, proving clear-on-read.
REQ-043 lbp_valid pulsed during CLEAR: drop_err=1 and stays 1 through later frames until reset.
REQ-044 Reset asserted during READOUT at bin 100: outputs go to 0 immediately; after release, CLEAR lasts 256 cycles, then acc_ready=1.

Source files
------------

// File: rtl/lbp_hist_pkg.sv
// Shared constants, FSM encoding and the border test for the LBP histogram block.
package lbp_hist_pkg;

    localparam int unsigned IMG_DIM   = 128;
    localparam int unsigned NUM_BINS  = 256;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned COORD_W   = 7;
    localparam int unsigned BIN_W     = 8;
    localparam int unsigned BORDER_LO = 0;
    localparam int unsigned BORDER_HI = IMG_DIM - 1;

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_ACCUM   = 3'd1,
        S_DRAIN   = 3'd2,
        S_READOUT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // True when the pixel (row in upper bits, column in lower bits) sits on the image edge.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        row = addr[ADDR_W-1:COORD_W];
        col = addr[COORD_W-1:0];
        return (row == COORD_W'(BORDER_LO)) || (row == COORD_W'(BORDER_HI)) ||
               (col == COORD_W'(BORDER_LO)) || (col == COORD_W'(BORDER_HI));
    endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// Histogram bin storage: one synchronous read port, one write port, read returns pre-write data.
module lbp_hist_ram
    import lbp_hist_pkg::*;
#(
    parameter int unsigned CNT_W = 15
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [BIN_W-1:0] i_waddr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic [BIN_W-1:0] i_raddr,
    output logic [CNT_W-1:0] o_rdata
);

    logic [CNT_W-1:0] r_mem [NUM_BINS];
    logic [CNT_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: clear, accumulate with forwarded read-modify-write, drain, clear-on-read readout.
module lbp_hist
    import lbp_hist_pkg::*;
#(
    parameter int unsigned EXCL_BORDER = 1,
    parameter int unsigned CNT_W       = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lbp_valid,
    input  logic [ADDR_W-1:0] i_lbp_addr,
    input  logic [BIN_W-1:0]  i_lbp_data,
    input  logic              i_finish,
    output logic              o_acc_ready,
    output logic              o_hist_valid,
    input  logic              i_hist_ready,
    output logic [BIN_W-1:0]  o_hist_bin,
    output logic [CNT_W-1:0]  o_hist_count,
    output logic              o_hist_done,
    output logic              o_drop_err
);

    localparam int unsigned PTR_W = BIN_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_clr_cnt;
    logic               r_drain_cnt;

    logic               r_s1_valid;
    logic [BIN_W-1:0]   r_s1_bin;
    logic               r_lw_valid;
    logic [BIN_W-1:0]   r_lw_bin;
    logic [CNT_W-1:0]   r_lw_data;

    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_rd_pend;
    logic [BIN_W-1:0]   r_pend_bin;

    logic               r_acc_ready;
    logic               r_hist_valid;
    logic [BIN_W-1:0]   r_hist_bin;
    logic [CNT_W-1:0]   r_hist_count;
    logic               r_hist_done;
    logic               r_drop_err;

    logic               w_accum;
    logic               w_take;
    logic               w_accept;
    logic               w_rd_issue;
    logic [BIN_W-1:0]   w_raddr;
    logic [CNT_W-1:0]   w_rdata;
    logic [CNT_W-1:0]   w_old;
    logic [CNT_W-1:0]   w_inc;
    logic               w_we;
    logic [BIN_W-1:0]   w_waddr;
    logic [CNT_W-1:0]   w_wdata;

    assign w_accum    = (r_state == S_ACCUM);
    assign w_take     = i_lbp_valid && w_accum && !((EXCL_BORDER != 0) && is_border(i_lbp_addr));
    assign w_accept   = r_hist_valid && i_hist_ready;
    assign w_rd_issue = (r_state == S_READOUT) && !r_rd_ptr[PTR_W-1] && !r_rd_pend &&
                        (!r_hist_valid || w_accept);
    assign w_raddr    = w_accum ? i_lbp_data : r_rd_ptr[BIN_W-1:0];

    // The write committed last cycle is not yet visible to a read issued in that same cycle.
    assign w_old = (r_lw_valid && (r_lw_bin == r_s1_bin)) ? r_lw_data : w_rdata;
    assign w_inc = (w_old == CNT_MAX) ? w_old : w_old + CNT_W'(1);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
        end else if (r_s1_valid) begin
            w_we    = 1'b1;
            w_waddr = r_s1_bin;
            w_wdata = w_inc;
        end else if (w_accept) begin
            w_we    = 1'b1;
            w_waddr = r_hist_bin;
        end
    end

    lbp_hist_ram #(
        .CNT_W (CNT_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR:   if (r_clr_cnt == LAST_BIN) w_next = S_ACCUM;
            S_ACCUM:   if (i_finish) w_next = S_DRAIN;
            S_DRAIN:   if (r_drain_cnt) w_next = S_READOUT;
            S_READOUT: if (w_accept && (r_hist_bin == LAST_BIN)) w_next = S_DONE;
            S_DONE:    w_next = S_ACCUM;
            default:   w_next = S_CLEAR;
        endcase
    end

    // Sequencing counters and the increment pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt   <= '0;
            r_drain_cnt <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_bin    <= '0;
            r_lw_valid  <= 1'b0;
            r_lw_bin    <= '0;
            r_lw_data   <= '0;
        end else begin
            r_clr_cnt   <= (r_state == S_CLEAR) ? r_clr_cnt + BIN_W'(1) : '0;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_s1_valid  <= w_take;
            r_s1_bin    <= i_lbp_data;
            r_lw_valid  <= r_s1_valid;
            r_lw_bin    <= r_s1_bin;
            r_lw_data   <= w_inc;
        end
    end

    // Readout: one read in flight, output beat held until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr     <= '0;
            r_rd_pend    <= 1'b0;
            r_pend_bin   <= '0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
        end else if (r_state != S_READOUT) begin
            r_rd_ptr     <= '0;
            r_rd_pend    <= 1'b0;
            r_hist_valid <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_pend_bin <= r_rd_ptr[BIN_W-1:0];
            end
            if (r_rd_pend) begin
                r_hist_valid <= 1'b1;
                r_hist_bin   <= r_pend_bin;
                r_hist_count <= w_rdata;
            end else if (w_accept) begin
                r_hist_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_ready <= 1'b0;
            r_hist_done <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_acc_ready <= (w_next == S_ACCUM);
            r_hist_done <= (w_next == S_DONE);
            if (i_lbp_valid && !w_accum) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign o_acc_ready  = r_acc_ready;
    assign o_hist_valid = r_hist_valid;
    assign o_hist_bin   = r_hist_bin;
    assign o_hist_count = r_hist_count;
    assign o_hist_done  = r_hist_done;
    assign o_drop_err   = r_drop_err;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: an array histogram model checked against every readout beat.
module tb_lbp_hist;

    localparam int CNT_W = 15;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lbp_valid = 1'b0;
    logic [13:0]       lbp_addr = '0;
    logic [7:0]        lbp_data = '0;
    logic              finish = 1'b0;
    logic              hist_ready = 1'b1;
    logic              acc_ready;
    logic              hist_valid;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_done;
    logic              drop_err;

    lbp_hist #(.EXCL_BORDER(1), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_lbp_valid  (lbp_valid),
        .i_lbp_addr   (lbp_addr),
        .i_lbp_data   (lbp_data),
        .i_finish     (finish),
        .o_acc_ready  (acc_ready),
        .o_hist_valid (hist_valid),
        .i_hist_ready (hist_ready),
        .o_hist_bin   (hist_bin),
        .o_hist_count (hist_count),
        .o_hist_done  (hist_done),
        .o_drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int model [256];
    int got   [256];
    int exp_bin = 0;
    int beats = 0;
    int done_cnt = 0;
    bit done_due = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;
    int prev_bin = 0;
    int prev_cnt = 0;
    int ready_mode = 0;
    int rcyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Downstream ready: constant 1, or the repeating 1-0-0-1 stall pattern.
    always @(posedge clk) begin
        #1;
        rcyc++;
        if (ready_mode == 0) hist_ready = 1'b1;
        else hist_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
    end

    // Compare process: every readout beat against the model, stalls, and the done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (done_due) begin
                check("hist_done_pulse", 64'(hist_done), 64'd1);
                done_due = 1'b0;
            end else if (hist_done) begin
                check("hist_done_spurious", 64'(hist_done), 64'd0);
            end
            if (hist_done) done_cnt++;
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 64'(hist_valid), 64'd1);
                check("stall_bin", 64'(hist_bin), 64'(prev_bin));
                check("stall_count", 64'(hist_count), 64'(prev_cnt));
            end
            if (hist_valid) begin
                check("acc_ready_in_readout", 64'(acc_ready), 64'd0);
                if (exp_bin > 255) begin
                    check("beat_extra", 64'(exp_bin), 64'd255);
                end else begin
                    check("beat_bin", 64'(hist_bin), 64'(exp_bin));
                    check("beat_count", 64'(hist_count), 64'(model[exp_bin]));
                end
                if (hist_ready) begin
                    got[hist_bin] = int'(hist_count);
                    beats++;
                    if (exp_bin == 255) done_due = 1'b1;
                    exp_bin++;
                end
            end
            prev_valid = hist_valid;
            prev_ready = hist_ready;
            prev_bin   = int'(hist_bin);
            prev_cnt   = int'(hist_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        exp_bin  = 0;
        beats    = 0;
        done_cnt = 0;
        for (int i = 0; i < 256; i++) got[i] = -1;
    endtask

    task automatic send(input int a, input int d, input bit fin);
        int row;
        int col;
        lbp_valid = 1'b1;
        lbp_addr  = 14'(a);
        lbp_data  = 8'(d);
        finish    = fin;
        row = a / 128;
        col = a % 128;
        if (acc_ready && !(row == 0 || row == 127 || col == 0 || col == 127))
            if (model[d] < CMAX) model[d]++;
        step();
        lbp_valid = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    // Wait for the done pulse; the model then reflects clear-on-read.
    task automatic readout();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            step();
            n++;
        end
        check("readout_finished", 64'(done_cnt), 64'd1);
        check("readout_beats", 64'(beats), 64'd256);
        for (int i = 0; i < 256; i++) model[i] = 0;
    endtask

    // Cycles from reset release until acc_ready; optionally pokes lbp_valid during CLEAR.
    task automatic clear_len(input bit poke, output int cyc);
        cyc = 0;
        while (cyc < 400) begin
            step();
            cyc++;
            if (acc_ready) break;
            lbp_valid = poke && (cyc == 10);
        end
        lbp_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int nz;
        int n;
        for (int i = 0; i < 256; i++) begin
            model[i] = 0;
            got[i]   = -1;
        end

        #1;
        check("rst_acc_ready", 64'(acc_ready), 64'd0);
        check("rst_hist_valid", 64'(hist_valid), 64'd0);
        check("rst_hist_bin", 64'(hist_bin), 64'd0);
        check("rst_hist_count", 64'(hist_count), 64'd0);
        check("rst_hist_done", 64'(hist_done), 64'd0);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        clear_len(1'b0, cyc);
        check("clear_cycles", 64'(cyc), 64'd256);

        // Frame A: full raster of code 0; border excluded leaves 126*126.
        begin_frame();
        for (int i = 0; i < 16384; i++) send(i, 0, 1'b0);
        pulse_finish();
        check("accept_closed_after_finish", 64'(acc_ready), 64'd0);
        readout();
        check("A_bin0_literal", 64'(got[0]), 64'd15876);
        check("A_bin1_literal", 64'(got[1]), 64'd0);
        check("A_bin255_literal", 64'(got[255]), 64'd0);

        // Frame B: back-to-back and alternate repeats, border samples, finish with last sample; stalled readout.
        begin_frame();
        ready_mode = 1;
        send(1290, 5, 1'b0);
        send(1291, 5, 1'b0);
        send(1292, 5, 1'b0);
        send(1293, 7, 1'b0);
        send(1294, 5, 1'b0);
        send(5, 7, 1'b0);
        send(5 * 128 + 127, 7, 1'b0);
        send(1300, 3, 1'b0);
        send(1301, 4, 1'b0);
        send(1302, 3, 1'b1);
        check("B_model_bin5", 64'(model[5]), 64'd4);
        readout();
        ready_mode = 0;
        check("B_bin5_literal", 64'(got[5]), 64'd4);
        check("B_bin7_literal", 64'(got[7]), 64'd1);
        check("B_bin3_literal", 64'(got[3]), 64'd2);
        check("B_bin4_literal", 64'(got[4]), 64'd1);
        check("B_bin0_cleared", 64'(got[0]), 64'd0);

        // Frame C: straight after the done pulse, no CLEAR in between.
        check("C_acc_ready_after_done", 64'(acc_ready), 64'd1);
        begin_frame();
        for (int i = 0; i < 10; i++) send(2000 + i, 255, 1'b0);
        pulse_finish();
        readout();
        nz = 0;
        for (int i = 0; i < 255; i++) if (got[i] != 0) nz++;
        check("C_bin255_literal", 64'(got[255]), 64'd10);
        check("C_other_bins_zero", 64'(nz), 64'd0);
        check("C_drop_err_clean", 64'(drop_err), 64'd0);

        // Frame D: reset while bin 100 is presented.
        begin_frame();
        for (int i = 0; i < 10; i++) send(3000 + i, 17, 1'b0);
        pulse_finish();
        n = 0;
        while (!(hist_valid && hist_bin == 8'd100) && n < 2000) begin
            step();
            n++;
        end
        check("D_reached_bin100", 64'(hist_bin), 64'd100);
        #1;
        rst_n = 1'b0;
        #1;
        check("D_rst_acc_ready", 64'(acc_ready), 64'd0);
        check("D_rst_hist_valid", 64'(hist_valid), 64'd0);
        check("D_rst_hist_bin", 64'(hist_bin), 64'd0);
        check("D_rst_hist_count", 64'(hist_count), 64'd0);
        for (int i = 0; i < 256; i++) model[i] = 0;
        step();
        step();
        begin_frame();
        rst_n = 1'b1;
        clear_len(1'b1, cyc);
        check("D_clear_cycles", 64'(cyc), 64'd256);
        check("D_drop_err_set", 64'(drop_err), 64'd1);

        // Frame E: partial counts discarded; drop_err stays sticky.
        begin_frame();
        for (int i = 0; i < 3; i++) send(4000 + i, 32, 1'b0);
        pulse_finish();
        readout();
        check("E_bin32_literal", 64'(got[32]), 64'd3);
        check("E_bin17_discarded", 64'(got[17]), 64'd0);
        check("E_drop_err_sticky", 64'(drop_err), 64'd1);

        rst_n = 1'b0;
        #1;
        check("final_rst_drop_err", 64'(drop_err), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
